// File: rtl/complex_div_arbiter.sv
`default_nettype none
// complex_div_arbiter -- round-robin sharing of one complex divider; an in-order ID FIFO routes results back.
// Define CDIV_ARB_PERF_EN to build saturating perf_ops_o / perf_stall_o counters (tied to 0 otherwise). Rev 1.0
module complex_div_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int DEPTH   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*4*WIDTH-1:0]     req_operands_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [2*WIDTH-1:0]             rsp_result_o,
    output logic [4:0]                     rsp_status_o,
    output logic                           div_in_valid_o,
    input  logic                           div_in_ready_i,
    output logic [4*WIDTH-1:0]             div_operands_o,
    output logic                           div_flush_o,
    input  logic                           div_out_valid_i,
    output logic                           div_out_ready_o,
    input  logic [2*WIDTH-1:0]             div_result_i,
    input  logic [4:0]                     div_status_i,
    input  logic                           div_busy_i,
    output logic                           busy_o,
    output logic [31:0]                    perf_ops_o,
    output logic [31:0]                    perf_stall_o
);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OPW = 4 * WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          flush_first;
    logic          accept_en;
    logic          drain;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic [IW:0]   cand;
    logic [IW-1:0] id_fifo [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [IW-1:0] head;
    logic          fifo_empty;
    logic          has_room;
    logic          route_ok;
    logic          push;
    logic          pop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            flush_first <= 1'b0;
        end else begin
            state       <= state_next;
            flush_first <= flush_i;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:   if (push) state_next = ST_ACTIVE;
                ST_ACTIVE: if (count_next == '0) state_next = ST_IDLE;
                ST_FLUSH:  if (!div_busy_i && !div_out_valid_i) state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        drain       = (state == ST_FLUSH);
        accept_en   = !drain && !flush_i;   // flush wins over a same-cycle request
        div_flush_o = drain && flush_first;
        busy_o      = (count != '0) || drain;
    end

    // Round-robin search starting at ptr
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            if (!grant_any && req_valid_i[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    assign has_room       = (count < (AW+1)'(DEPTH));
    assign div_in_valid_o = grant_any && has_room && accept_en;
    assign push           = div_in_valid_o && div_in_ready_i;

    always_comb begin
        div_operands_o = '0;
        req_ready_o    = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_idx == IW'(r)) begin
                div_operands_o = req_operands_i[r*OPW +: OPW];
                req_ready_o[r] = push;
            end
        end
    end

    // Response routing: the FIFO head names the owner of the divider's current result
    assign head       = id_fifo[rd_ptr];
    assign fifo_empty = (count == '0);
    assign route_ok   = !fifo_empty && !drain;
    // Empty FIFO outside flush is a protocol error: accept and drop the stray result
    assign div_out_ready_o = drain || fifo_empty || rsp_ready_i[head];
    assign pop             = div_out_valid_i && div_out_ready_o && route_ok;
    assign rsp_result_o    = div_result_i;
    assign rsp_status_o    = div_status_i;

    always_comb begin
        rsp_valid_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_valid_o[r] = div_out_valid_i && route_ok && (head == IW'(r));
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || div_flush_o) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) id_fifo[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef CDIV_ARB_PERF_EN
    logic [31:0] ops_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ops_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && (ops_cnt != '1)) ops_cnt <= ops_cnt + 1'b1;
            if ((|req_valid_i) && !push && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign perf_ops_o   = ops_cnt;
    assign perf_stall_o = stall_cnt;
`else
    assign perf_ops_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_complex_div_arbiter.sv
`default_nettype none
// tb_complex_div_arbiter -- directed stimulus, behavioural divider, queue-based reference checked every cycle.
module tb_complex_div_arbiter;
    localparam int N   = 4;
    localparam int W   = 64;
    localparam int D   = 4;
    localparam int OPW = 4 * W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*OPW-1:0]   req_operands;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready;
    logic [2*W-1:0]     rsp_result;
    logic [4:0]         rsp_status;
    logic               div_in_valid;
    logic               div_in_ready;
    logic [OPW-1:0]     div_operands;
    logic               div_flush;
    logic               div_out_valid;
    logic               div_out_ready;
    logic [2*W-1:0]     div_result;
    logic [4:0]         div_status;
    logic               div_busy;
    logic               busy;
    logic [31:0]        perf_ops;
    logic [31:0]        perf_stall;

    always #5 clk = ~clk;

    complex_div_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_status_o(rsp_status), .div_in_valid_o(div_in_valid), .div_in_ready_i(div_in_ready),
        .div_operands_o(div_operands), .div_flush_o(div_flush), .div_out_valid_i(div_out_valid),
        .div_out_ready_o(div_out_ready), .div_result_i(div_result), .div_status_i(div_status),
        .div_busy_i(div_busy), .busy_o(busy), .perf_ops_o(perf_ops), .perf_stall_o(perf_stall)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural divider: fixed latency, holds its output until accepted
    typedef struct { logic [2*W-1:0] res; logic [4:0] st; int rdy; } dq_t;
    dq_t divq[$];
    int  cyc = 0;
    int  lat = 2;

    function automatic logic [2*W-1:0] cdiv(input logic [OPW-1:0] op);
        real a, b, c, d, den;
        a = $bitstoreal(op[255:192]);
        b = $bitstoreal(op[191:128]);
        c = $bitstoreal(op[127:64]);
        d = $bitstoreal(op[63:0]);
        den = c*c + d*d;
        return {$realtobits((b*c - a*d) / den), $realtobits((a*c + b*d) / den)};
    endfunction

    // Requesters hold valid until each pending op is accepted
    int           want [N];
    logic [N-1:0] hs_pend;
    int           grants[$];
    int           deliv[$];
    int           flush_pulses = 0;
    logic [N-1:0] last_rv;
    logic [2*W-1:0] last_res;

    // Reference model state
    int          mq[$];
    int          mptr;
    int          mst;          // 0 idle, 1 active, 2 flush
    bit          mfirst;
    int unsigned mops;
    int unsigned mstall;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < N; r++) begin
            if (hs_pend[r] && want[r] > 0) want[r]--;
            req_valid[r] = (want[r] > 0);
        end
        hs_pend = '0;
        div_busy      = (divq.size() > 0);
        div_out_valid = (divq.size() > 0) && (cyc >= divq[0].rdy);
        div_result    = (divq.size() > 0) ? divq[0].res : '0;
        div_status    = (divq.size() > 0) ? divq[0].st : '0;
    endtask

    task automatic set_want(input int r, input int n);
        want[r] = n;
        req_valid[r] = (n > 0);
    endtask

    function automatic bit any_want();
        for (int r = 0; r < N; r++) if (want[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((any_want() || divq.size() > 0 || busy) && n < max) begin
            step();
            n++;
        end
        if (any_want() || divq.size() > 0 || busy) begin
            vecs++;
            errs++;
            $display("FAIL timeout: still busy after %0d cycles, required idle", max);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Compare process: reference outputs derived from the model, then advance the model
    always @(negedge clk) begin
        int          cnt;
        int          g;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rv;
        logic        e_inv, e_ordy, e_fl, e_busy, e_push, e_pop, head_ok;
        if (!rst_n) begin
            mq.delete();
            divq.delete();
            mptr = 0; mst = 0; mfirst = 1'b0; mops = 0; mstall = 0;
            hs_pend = '0;
        end else begin
            cnt = mq.size();
            g = -1;
            for (int i = 0; i < N; i++)
                if (g < 0 && req_valid[(mptr + i) % N]) g = (mptr + i) % N;
            e_inv = (mst != 2) && !flush && (cnt < D) && (g >= 0);
            e_rdy = '0;
            if (e_inv && div_in_ready) e_rdy[g] = 1'b1;
            head_ok = (cnt > 0) && (mst != 2);
            e_rv = '0;
            if (div_out_valid && head_ok) e_rv[mq[0]] = 1'b1;
            e_ordy = 1'b1;
            if (mst != 2 && cnt > 0) e_ordy = rsp_ready[mq[0]];
            e_fl   = (mst == 2) && mfirst;
            e_busy = (cnt > 0) || (mst == 2);

            chk("div_in_valid", div_in_valid, e_inv);
            chk("req_ready", req_ready, e_rdy);
            if (e_inv) chk("div_operands", div_operands, req_operands[g*OPW +: OPW]);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("div_out_ready", div_out_ready, e_ordy);
            chk("div_flush", div_flush, e_fl);
            chk("busy", busy, e_busy);
            if (rsp_valid != '0) begin
                chk("rsp_result", rsp_result, div_result);
                chk("rsp_status", rsp_status, div_status);
            end
`ifdef CDIV_ARB_PERF_EN
            chk("perf_ops", perf_ops, mops);
            chk("perf_stall", perf_stall, mstall);
`else
            chk("perf_ops", perf_ops, 0);
            chk("perf_stall", perf_stall, 0);
`endif
            // stimulus bookkeeping follows the DUT's actual handshakes
            hs_pend = req_ready & req_valid;
            for (int r = 0; r < N; r++) begin
                if (hs_pend[r]) grants.push_back(r);
                if (rsp_valid[r] && rsp_ready[r]) deliv.push_back(r);
            end
            if (div_out_valid && div_out_ready) void'(divq.pop_front());
            if (div_in_valid && div_in_ready)
                divq.push_back('{res: cdiv(div_operands), st: 5'(cyc), rdy: cyc + lat});
            if (rsp_valid != '0) begin
                last_rv  = rsp_valid;
                last_res = rsp_result;
            end
            if (div_flush) flush_pulses++;

            e_push = e_inv && div_in_ready;
            e_pop  = div_out_valid && e_ordy && head_ok;
            if (e_pop) begin
                void'(mq.pop_front());
                if (mops != 32'hffff_ffff) mops++;
            end
            if (e_push) begin
                mq.push_back(g);
                mptr = (g + 1) % N;
            end
            if (req_valid != '0 && !e_push && mstall != 32'hffff_ffff) mstall++;
            if (e_fl) mq.delete();
            if (flush) begin
                mst = 2; mfirst = 1'b1;
            end else if (mst == 2) begin
                mfirst = 1'b0;
                if (!div_busy && !div_out_valid) mst = 0;
            end else begin
                mst = (mq.size() > 0) ? 1 : 0;
            end
        end
    end

    initial begin
        logic [63:0] a, b, c, d;
        rst_n = 1'b0; flush = 1'b0; req_valid = '0; rsp_ready = '1; div_in_ready = 1'b1;
        div_out_valid = 1'b0; div_result = '0; div_status = '0; div_busy = 1'b0;
        hs_pend = '0; last_rv = '0; last_res = '0;
        for (int r = 0; r < N; r++) begin
            want[r] = 0;
            a = $realtobits(real'(r + 1)); b = $realtobits(2.0);
            c = $realtobits(1.0);          d = $realtobits(real'(r + 1));
            if (r == 2) begin
                a = $realtobits(7.0); d = $realtobits(2.0);
            end
            req_operands[r*OPW +: OPW] = {a, b, c, d};
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("reset busy", busy, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset div_flush", div_flush, 0);
        chk("reset perf_ops", perf_ops, 0);
        chk("reset perf_stall", perf_stall, 0);

        // single request from requester 2: (7+j2)/(1+j2) = 2.2 - j2.4
        grants.delete();
        set_want(2, 1);
        run_idle(50);
        chk("t1 grant count", grants.size(), 1);
        if (grants.size() > 0) chk("t1 grant id", grants[0], 2);
        chk("t1 rsp_valid", last_rv, 4'b0100);
        chk("t1 result", last_res, {$realtobits(-2.4), $realtobits(2.2)});
        chk("t1 busy", busy, 0);

        // all four continuously valid: rotation, stall at DEPTH, push+pop at full occupancy
        do_reset();
        grants.delete();
        rsp_ready = '0;
        for (int r = 0; r < N; r++) set_want(r, 3);
        repeat (8) step();
        chk("t2 grants at full", grants.size(), 4);
        chk("t2 busy at full", busy, 1);
        rsp_ready = '1;
        run_idle(200);
        chk("t2 grant total", grants.size(), 12);
        for (int i = 0; i < 12 && i < grants.size(); i++) chk("t2 grant order", grants[i], i % 4);

        // head requester not ready for several cycles: result held, no reordering
        deliv.delete();
        rsp_ready = 4'b1101;
        set_want(1, 1);
        set_want(3, 1);
        repeat (7) step();
        chk("t3 held out_ready", div_out_ready, 0);
        chk("t3 held rsp_valid", rsp_valid, 4'b0010);
        chk("t3 none delivered", deliv.size(), 0);
        rsp_ready = '1;
        run_idle(50);
        chk("t3 delivered", deliv.size(), 2);
        if (deliv.size() == 2) begin
            chk("t3 first", deliv[0], 1);
            chk("t3 second", deliv[1], 3);
        end

        // flush with 3 outstanding, re-flush while draining, then normal service
        lat = 8;
        deliv.delete();
        flush_pulses = 0;
        for (int r = 0; r < 3; r++) set_want(r, 1);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_idle(100);
        chk("t5 flush pulses", flush_pulses, 2);
        chk("t5 dropped", deliv.size(), 0);
        chk("t5 idle", busy, 0);
        lat = 2;
        set_want(3, 1);
        run_idle(50);
        chk("t5 served after", deliv.size(), 1);
        if (deliv.size() == 1) chk("t5 served id", deliv[0], 3);

        // stray divider result with nothing outstanding is swallowed
        divq.push_back('{res: '1, st: 5'h1f, rdy: cyc});
        step();
        chk("err out_ready", div_out_ready, 1);
        chk("err rsp_valid", rsp_valid, 0);
        run_idle(20);

        // perf: 3 stalled cycles then 8 completed operations
        do_reset();
        div_in_ready = 1'b0;
        for (int r = 0; r < N; r++) set_want(r, 2);
        repeat (3) step();
        div_in_ready = 1'b1;
        run_idle(100);
`ifdef CDIV_ARB_PERF_EN
        chk("perf ops total", perf_ops, 8);
        chk("perf stall total", perf_stall, 3);
`else
        chk("perf ops total", perf_ops, 0);
        chk("perf stall total", perf_stall, 0);
`endif
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/complex_div_arbiter.md
# complex_div_arbiter

Round-robin arbiter that shares one `complex_div` unit among `NUM_REQ` requesters. It sits in front of the divider's input handshake and behind its output handshake. It records the requester ID of every accepted operation in an in-order ID FIFO and routes each result back to the requester that issued it. It also sequences flushes, limits outstanding work to `DEPTH`, and reports busy state.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 64: operand/result width (FP64).
- `DEPTH`, 4: maximum outstanding divider operations; power of two, ≥ divider pipeline depth.

Clock and reset: one clock; reset is synchronous and active-low.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous, active-low reset.
- `flush_i`  in  1  abort all in-flight work.
- `req_valid_i`  in  NUM_REQ  per-requester valid.
- `req_ready_o`  out  NUM_REQ  per-requester ready.
- `req_operands_i`  in  NUM_REQ×4×WIDTH  a, b, c, d per requester.
- `rsp_valid_o`  out  NUM_REQ  one-hot result valid.
- `rsp_ready_i`  in  NUM_REQ  per-requester result ready.
- `rsp_result_o`  out  2×WIDTH  {imag, real}, shared by all requesters.
- `rsp_status_o`  out  fpnew_pkg::status_t  result status, shared.
- `div_in_valid_o` / `div_in_ready_i`  out/in  1  divider input handshake.
- `div_operands_o`  out  4×WIDTH  operands to the divider.
- `div_flush_o`  out  1  divider flush.
- `div_out_valid_i` / `div_out_ready_o`  in/out  1  divider output handshake.
- `div_result_i`  in  2×WIDTH  divider result.
- `div_status_i`  in  status_t  divider status.
- `div_busy_i`  in  1  divider busy.
- `busy_o`  out  1  outstanding count nonzero, or in FLUSH.
- `perf_ops_o`  out  32  completed-operation count (see Configuration).
- `perf_stall_o`  out  32  stall-cycle count (see Configuration).

## Operation
**States**
- IDLE: count = 0.
- ACTIVE: count > 0.
- FLUSH.
- Transitions:
  - IDLE→ACTIVE on an accepted request.
  - ACTIVE→IDLE when count returns to 0.
  - Any state→FLUSH on `flush_i`.
  - FLUSH→IDLE when `div_busy_i` = 0 and `div_out_valid_i` = 0.

**Arbitration**
- Rotating priority pointer `ptr`.
- The grant goes to the first requester at or after `ptr` with `req_valid_i` set.
- `req_ready_o[g]` = grant[g] & `div_in_ready_i` & (count < DEPTH) & state≠FLUSH.
- All other ready bits are 0.
- `div_in_valid_o` = any valid & (count < DEPTH) & state≠FLUSH.
- `div_operands_o` = operands of the granted requester. The mux is combinational.
- On a handshake:
  - push g into the ID FIFO;
  - set `ptr` ← (g+1) mod NUM_REQ.
- `ptr` does not move without a handshake.

**Response routing**
- head = ID FIFO head.
- `rsp_valid_o[head]` = `div_out_valid_i` & FIFO not empty & state≠FLUSH.
- `div_out_ready_o` = `rsp_ready_i[head]` in ACTIVE, and 1 in FLUSH (drain).
- On an output handshake, pop the FIFO.
- `rsp_result_o` and `rsp_status_o` are passthroughs of the divider outputs.

**Outstanding count**
- count +1 on push, −1 on pop.
- A push and a pop in the same cycle leave count unchanged; both FIFO pointers advance.
- Pointers wrap modulo DEPTH.

**Flush**
- `div_flush_o` is 1 for exactly the first FLUSH cycle.
- In that cycle the ID FIFO and count clear.
- Divider results arriving during FLUSH are consumed and dropped.
- `flush_i` asserted while already in FLUSH re-pulses `div_flush_o`.
- `flush_i` has priority over a same-cycle request handshake; that request is not accepted.

**Errors**
- `div_out_valid_i` with an empty FIFO outside FLUSH is a protocol error.
- The result is dropped: `div_out_ready_o` = 1, no `rsp_valid_o` bit set.

## Timing
- Reset values:
  - state IDLE, `ptr` = 0, count = 0, FIFO empty;
  - all `*_valid_o`, `req_ready_o`, `div_flush_o`, `busy_o` = 0;
  - perf counters = 0.
- Arbitration and response routing are combinational. The arbiter adds zero latency in either direction.
- Total latency = divider latency.
- Reset asserted mid-operation discards all tracking. The integrator must reset the divider in the same cycle.
- Back-to-back grants to different requesters are allowed every cycle while count < DEPTH.

## Configuration
- `CDIV_ARB_PERF_EN` defined:
  - `perf_ops_o` increments on each routed output handshake;
  - `perf_stall_o` increments on each cycle with some `req_valid_i` set but no handshake;
  - both saturate at 2^32−1;
  - both clear on reset.
- `CDIV_ARB_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Single request, requester 2: a=7, b=2, c=1, d=2. Expected: one `req_ready_o[2]` pulse; `rsp_valid_o` = 4'b0100 with result 2.2 − j2.4; count back to 0; `busy_o` falls.
- All four requesters valid continuously, `div_in_ready_i` = 1. Expected: grant order 0,1,2,3,0…; stalls once count = DEPTH = 4 until a pop.
- Responses with `rsp_ready_i[head]` = 0 for 5 cycles. Expected: `div_out_ready_o` = 0, result held, no reordering; other requesters' responses are not delivered out of order.
- Same-cycle push and pop at count = 4. Expected: count stays 4; pointers wrap correctly over 10 operations.
- `flush_i` with 3 outstanding. Expected: one-cycle `div_flush_o`; late results dropped with no `rsp_valid_o`; IDLE after `div_busy_i` falls; the next request is served normally.
- With `CDIV_ARB_PERF_EN`, 8 completed operations and 3 stalled cycles. Expected: `perf_ops_o` = 8, `perf_stall_o` = 3. Without the macro, both read 0.
